rc4_key_search_ctrl: RTL and testbench
======================================

RC4_KEY_SEARCH_CTRL -- requirements
Module: rc4_key_search_ctrl

Interface
REQ-001 SHALL have parameter KEY_BITS, default 22, width of the candidate key counter.
REQ-002 SHALL have parameter KEY_START, default 0, first candidate key.
REQ-003 SHALL have parameter KEY_END, default 22'h3FFFFF, last candidate key (KEY_END >= KEY_START).
REQ-004 SHALL have parameter MSG_LEN, default 32, number of result bytes checked (1..32).
REQ-005 SHALL have port clk  input  1  rising-edge clock.
REQ-006 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port start  input  1  level; begin a search.
REQ-008 SHALL have ports init_start, shuffle_start, decrypt_start  output  1 each  single-cycle launch pulses to the S-init, key-schedule and decrypt engines.
REQ-009 SHALL have ports init_done, shuffle_done, decrypt_done  input  1 each  single-cycle completion pulses from those engines.
REQ-010 SHALL have port s_mem_sel  output  2  S-memory owner: 0 init, 1 shuffle, 2 decrypt, 3 none.
REQ-011 SHALL have port secret_key  output  24  current candidate, zero-extended from KEY_BITS.
REQ-012 SHALL have ports result_addr  output  5  and result_q  input  8  result-RAM read port (1-cycle read latency).
REQ-013 SHALL have ports busy, found, not_found  output  1 each  status.

Function
REQ-014 SHALL implement states IDLE, INIT, SHUFFLE, DECRYPT, CHECK, NEXT_KEY, FOUND, FAIL.
REQ-015 SHALL leave IDLE for INIT when start=1, loading key counter with KEY_START.
REQ-016 SHALL, in INIT/SHUFFLE/DECRYPT, pulse the matching *_start for exactly the first cycle of the state, then wait for the matching *_done.
REQ-017 SHALL transition INIT->SHUFFLE on init_done, SHUFFLE->DECRYPT on shuffle_done, DECRYPT->CHECK on decrypt_done.
REQ-018 SHALL ignore any *_done pulse not matching the current state.
REQ-019 SHALL drive s_mem_sel 0 in INIT, 1 in SHUFFLE, 2 in DECRYPT, 3 in all other states; at most one engine owns S-memory in any cycle.
REQ-020 SHALL, in CHECK, sweep result_addr 0..MSG_LEN-1 one address per cycle, evaluating result_q one cycle after each address.
REQ-021 SHALL treat a byte as valid iff 8'h61..8'h7A or 8'h20.
REQ-022 SHALL abort CHECK on first invalid byte and go to NEXT_KEY the cycle after that byte is evaluated.
REQ-023 SHALL go to FOUND when byte MSG_LEN-1 is evaluated valid; CHECK lasts MSG_LEN+1 cycles on success.
REQ-024 SHALL, in NEXT_KEY, go to FAIL if key == KEY_END, else increment key by 1 and go to INIT; key never wraps past KEY_END.
REQ-025 SHALL hold secret_key constant from INIT entry until NEXT_KEY exit; in FOUND it holds the matching key.
REQ-026 SHALL assert busy in INIT..NEXT_KEY, found only in FOUND, not_found only in FAIL; found and not_found never both 1.
REQ-027 SHALL remain in FOUND/FAIL until start=1, which restarts at INIT with KEY_START; start is ignored in all other states.
REQ-028 SHALL register all outputs (no combinational path from inputs to outputs).

Reset
REQ-029 SHALL on reset enter IDLE immediately with all *_start=0, s_mem_sel=3, secret_key=0, result_addr=0, busy=found=not_found=0.
REQ-030 SHALL on reset mid-search abandon the search with no start pulse issued in the reset cycle and none after release until start.

Verification
REQ-031 KEY_START=0,KEY_END=3; engines model key 2 valid ("hello world" + spaces) -> keys 0,1 rejected, found=1, secret_key=2, three init_start pulses total.
REQ-032 KEY_END=3, no key valid -> after key 3 rejected, not_found=1, secret_key=3, busy=0.
REQ-033 Key 0 result byte 0 = 8'h41 -> CHECK exits after 2 cycles, secret_key becomes 1; bytes 8'h7B, 8'h60, 8'h1F also rejected at their positions.
REQ-034 Spurious shuffle_done during INIT and decrypt_done during SHUFFLE -> no state change; s_mem_sel checked one-hot-by-state every cycle.
REQ-035 reset asserted during DECRYPT of key 5 -> outputs match REQ-029 same cycle; subsequent start restarts at KEY_START.
REQ-036 start held high in FOUND -> new search from KEY_START, found deasserts on INIT entry.

Source files
------------

// File: rtl/rc4_key_search_ctrl_if.sv
// rc4_key_search_ctrl_if
//   Handshake bundle between the RC4 key-search controller and its surroundings
//   (S-init / key-schedule / decrypt engines, result RAM, host start/status).
//   master : the controller (drives launches, S-memory owner, key, RAM address, status)
//   slave  : the environment (drives start, engine completions, RAM read data)
interface rc4_key_search_ctrl_if;
    logic        start;
    logic        init_start;
    logic        shuffle_start;
    logic        decrypt_start;
    logic        init_done;
    logic        shuffle_done;
    logic        decrypt_done;
    logic [1:0]  s_mem_sel;
    logic [23:0] secret_key;
    logic [4:0]  result_addr;
    logic [7:0]  result_q;
    logic        busy;
    logic        found;
    logic        not_found;

    modport master (
        input  start, init_done, shuffle_done, decrypt_done, result_q,
        output init_start, shuffle_start, decrypt_start, s_mem_sel,
               secret_key, result_addr, busy, found, not_found
    );

    modport slave (
        output start, init_done, shuffle_done, decrypt_done, result_q,
        input  init_start, shuffle_start, decrypt_start, s_mem_sel,
               secret_key, result_addr, busy, found, not_found
    );
endinterface

// File: rtl/rc4_key_search_ctrl.sv
// rc4_key_search_ctrl
//   Brute-force RC4 key search sequencer. For each candidate key from KEY_START
//   to KEY_END it launches S-init, key schedule and decrypt in turn, then reads
//   MSG_LEN decrypted bytes from the result RAM and accepts the key if every
//   byte is a lowercase letter or a space.
// Ports
//   clk    : rising-edge clock
//   reset  : asynchronous, active-high
//   bus    : rc4_key_search_ctrl_if.master
//            start (level), *_start launch pulses, *_done completion pulses,
//            s_mem_sel (0 init, 1 shuffle, 2 decrypt, 3 none),
//            secret_key (candidate, zero-extended), result_addr/result_q
//            (1-cycle read latency), busy/found/not_found status.
// All outputs come straight from flops.
module rc4_key_search_ctrl #(
    parameter int unsigned KEY_BITS  = 22,
    parameter int unsigned KEY_START = 0,
    parameter int unsigned KEY_END   = 22'h3FFFFF,
    parameter int unsigned MSG_LEN   = 32
) (
    input logic                   clk,
    input logic                   reset,
    rc4_key_search_ctrl_if.master bus
);
    localparam logic [KEY_BITS-1:0] KEY_FIRST = KEY_BITS'(KEY_START);
    localparam logic [KEY_BITS-1:0] KEY_LAST  = KEY_BITS'(KEY_END);
    localparam logic [5:0]          LAST_CYC  = 6'(MSG_LEN);      // cycle evaluating the final byte
    localparam logic [5:0]          LAST_ADDR = 6'(MSG_LEN - 1);

    typedef enum logic [2:0] {
        IDLE, INIT, SHUFFLE, DECRYPT, CHECK, NEXT_KEY, FOUND, FAIL
    } state_t;

    state_t              state;
    logic [KEY_BITS-1:0] key_q;
    logic [5:0]          chk_cyc;     // cycles spent in CHECK so far
    logic                init_start_q, shuffle_start_q, decrypt_start_q;
    logic [1:0]          sel_q;
    logic [4:0]          addr_q;
    logic                busy_q, found_q, not_found_q;
    logic                byte_ok;

    assign byte_ok = ((bus.result_q >= 8'h61) && (bus.result_q <= 8'h7A)) ||
                     (bus.result_q == 8'h20);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= IDLE;
            key_q           <= '0;
            chk_cyc         <= '0;
            init_start_q    <= 1'b0;
            shuffle_start_q <= 1'b0;
            decrypt_start_q <= 1'b0;
            sel_q           <= 2'd3;
            addr_q          <= '0;
            busy_q          <= 1'b0;
            found_q         <= 1'b0;
            not_found_q     <= 1'b0;
        end else begin
            // launch strobes are only ever high for the first cycle of a state
            init_start_q    <= 1'b0;
            shuffle_start_q <= 1'b0;
            decrypt_start_q <= 1'b0;
            case (state)
                IDLE, FOUND, FAIL: begin
                    if (bus.start) begin
                        state        <= INIT;
                        key_q        <= KEY_FIRST;
                        init_start_q <= 1'b1;
                        sel_q        <= 2'd0;
                        busy_q       <= 1'b1;
                        found_q      <= 1'b0;
                        not_found_q  <= 1'b0;
                    end
                end
                INIT: begin
                    if (bus.init_done) begin
                        state           <= SHUFFLE;
                        shuffle_start_q <= 1'b1;
                        sel_q           <= 2'd1;
                    end
                end
                SHUFFLE: begin
                    if (bus.shuffle_done) begin
                        state           <= DECRYPT;
                        decrypt_start_q <= 1'b1;
                        sel_q           <= 2'd2;
                    end
                end
                DECRYPT: begin
                    if (bus.decrypt_done) begin
                        state   <= CHECK;
                        sel_q   <= 2'd3;
                        chk_cyc <= '0;
                        addr_q  <= '0;
                    end
                end
                CHECK: begin
                    // address k is presented in cycle k; its byte arrives and is
                    // judged in cycle k+1, so cycle 0 has nothing to evaluate
                    chk_cyc <= chk_cyc + 6'd1;
                    if (chk_cyc < LAST_ADDR)
                        addr_q <= addr_q + 5'd1;
                    if (chk_cyc != 6'd0) begin
                        if (!byte_ok) begin
                            state <= NEXT_KEY;
                        end else if (chk_cyc == LAST_CYC) begin
                            state   <= FOUND;
                            busy_q  <= 1'b0;
                            found_q <= 1'b1;
                        end
                    end
                end
                NEXT_KEY: begin
                    if (key_q == KEY_LAST) begin
                        state       <= FAIL;
                        busy_q      <= 1'b0;
                        not_found_q <= 1'b1;
                    end else begin
                        state        <= INIT;
                        key_q        <= key_q + KEY_BITS'(1);
                        init_start_q <= 1'b1;
                        sel_q        <= 2'd0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.init_start    = init_start_q;
    assign bus.shuffle_start = shuffle_start_q;
    assign bus.decrypt_start = decrypt_start_q;
    assign bus.s_mem_sel     = sel_q;
    assign bus.secret_key    = 24'(key_q);
    assign bus.result_addr   = addr_q;
    assign bus.busy          = busy_q;
    assign bus.found         = found_q;
    assign bus.not_found     = not_found_q;
endmodule

// File: tb/tb_rc4_key_search_ctrl.sv
// tb_rc4_key_search_ctrl
//   Drives the key-search controller with modelled engines (random latency,
//   mismatched completion pulses mixed in) and a result RAM holding per-key
//   decrypted text. Expected outcome of each search is derived from where the
//   first non-[a-z ] byte sits for each key.
module tb_rc4_key_search_ctrl;
    localparam int KS = 0;
    localparam int KE = 7;
    localparam int ML = 32;

    logic clk = 1'b0;
    logic reset;

    rc4_key_search_ctrl_if bus ();

    rc4_key_search_ctrl #(
        .KEY_BITS (22),
        .KEY_START(KS),
        .KEY_END  (KE),
        .MSG_LEN  (ML)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.master)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [7:0]  ram [0:7][0:31];
    int          first_bad [0:7];

    // engine / monitor state
    int          phase = 3;      // engine currently owning S-memory (3 = none)
    int          cnt = 0;
    int          ck_cnt = 0;     // busy cycles with no engine active (check + next-key)
    int          init_cnt = 0;
    logic [23:0] cur_key = '0;
    logic [23:0] key_q[$];
    int          len_q[$];

    // reference expectations
    logic        exp_found;
    logic [23:0] exp_key;
    int          exp_inits;
    int          exp_len[$];

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] vchar();
        int r = int'($urandom_range(0, 26));
        return (r == 26) ? 8'h20 : 8'(8'h61 + r);
    endfunction

    function automatic logic [7:0] bchar();
        logic [7:0] b;
        do b = 8'($urandom_range(0, 255));
        while ((b >= 8'h61 && b <= 8'h7A) || b == 8'h20);
        return b;
    endfunction

    task automatic fill_key(int k, int fb, logic [7:0] badb);
        for (int a = 0; a < ML; a++) begin
            if (a < fb)       ram[k][a] = vchar();
            else if (a == fb) ram[k][a] = badb;
            else              ram[k][a] = 8'($urandom);
        end
        first_bad[k] = (fb >= ML) ? ML : fb;
    endtask

    // Outcome of a search: walk keys in order, first all-valid key wins.
    // Reject of a key at byte p costs p+2 check cycles plus one next-key cycle.
    task automatic compute_exp();
        exp_found = 1'b0;
        exp_inits = 0;
        exp_key   = '0;
        exp_len.delete();
        for (int k = KS; k <= KE; k++) begin
            exp_inits++;
            exp_key = 24'(k);
            if (first_bad[k] >= ML) begin
                exp_found = 1'b1;
                exp_len.push_back(ML + 1);
                break;
            end
            exp_len.push_back(first_bad[k] + 3);
        end
    endtask

    task automatic clear_obs();
        key_q.delete();
        len_q.delete();
        init_cnt = 0;
    endtask

    task automatic launch();
        compute_exp();
        clear_obs();
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_and_check(string tag);
        int n = 0;
        while (bus.found !== 1'b1 && bus.not_found !== 1'b1 && n < 4000) begin
            @(negedge clk);
            n++;
        end
        #1;
        chk({tag, ":done"}, 32'(n < 4000), 32'd1);
        chk({tag, ":found"}, 32'(bus.found), 32'(exp_found));
        chk({tag, ":not_found"}, 32'(bus.not_found), 32'(!exp_found));
        chk({tag, ":busy"}, 32'(bus.busy), 32'd0);
        chk({tag, ":key"}, 32'(bus.secret_key), 32'(exp_key));
        chk({tag, ":inits"}, 32'(init_cnt), 32'(exp_inits));
        chk({tag, ":keyseq_n"}, 32'(key_q.size()), 32'(exp_inits));
        for (int i = 0; i < key_q.size() && i < exp_inits; i++)
            chk({tag, ":keyseq"}, 32'(key_q[i]), 32'(KS + i));
        chk({tag, ":lens_n"}, 32'(len_q.size()), 32'(exp_len.size()));
        for (int i = 0; i < len_q.size() && i < exp_len.size(); i++)
            chk({tag, ":chk_len"}, 32'(len_q[i]), 32'(exp_len[i]));
    endtask

    // synchronous-read result RAM indexed by the current candidate
    always @(posedge clk)
        bus.result_q <= ram[bus.secret_key[2:0]][bus.result_addr];

    // engines + per-cycle monitor
    always @(negedge clk) begin
        if (reset) begin
            phase = 3;
            cnt = 0;
            ck_cnt = 0;
            bus.init_done = 1'b0;
            bus.shuffle_done = 1'b0;
            bus.decrypt_done = 1'b0;
        end else begin
            bus.init_done = 1'b0;
            bus.shuffle_done = 1'b0;
            bus.decrypt_done = 1'b0;
            if (bus.init_start === 1'b1) begin
                if (ck_cnt > 0) begin len_q.push_back(ck_cnt); ck_cnt = 0; end
                phase = 0;
                cnt = int'($urandom_range(0, 4));
                init_cnt++;
                cur_key = bus.secret_key;
                key_q.push_back(bus.secret_key);
            end
            if (bus.shuffle_start === 1'b1) begin phase = 1; cnt = int'($urandom_range(0, 4)); end
            if (bus.decrypt_start === 1'b1) begin phase = 2; cnt = int'($urandom_range(0, 4)); end
            if ((bus.found === 1'b1 || bus.not_found === 1'b1) && ck_cnt > 0) begin
                len_q.push_back(ck_cnt);
                ck_cnt = 0;
            end
            if (phase == 3 && bus.busy === 1'b1) ck_cnt++;

            chk("s_mem_sel", 32'(bus.s_mem_sel), 32'(phase));
            chk("found_excl", 32'(bus.found & bus.not_found), 32'd0);
            if (bus.busy === 1'b1) chk("key_hold", 32'(bus.secret_key), 32'(cur_key));

            if (phase != 3) begin
                if (cnt == 0) begin
                    case (phase)
                        0: bus.init_done = 1'b1;
                        1: bus.shuffle_done = 1'b1;
                        default: bus.decrypt_done = 1'b1;
                    endcase
                    phase = 3;
                end else begin
                    cnt--;
                    // completion pulses from the wrong engine must be ignored
                    if ($urandom_range(0, 1) == 1) begin
                        case (phase)
                            0: if ($urandom_range(0, 1) == 1) bus.shuffle_done = 1'b1;
                               else bus.decrypt_done = 1'b1;
                            1: if ($urandom_range(0, 1) == 1) bus.decrypt_done = 1'b1;
                               else bus.init_done = 1'b1;
                            default: bus.init_done = 1'b1;
                        endcase
                    end
                end
            end
        end
    end

    initial begin
        string hello;
        int    n;
        reset = 1'b1;
        bus.start = 1'b0;
        hello = "hello world";

        // reset state
        @(negedge clk);
        #2;
        chk("rst:init_start", 32'(bus.init_start), 32'd0);
        chk("rst:shuffle_start", 32'(bus.shuffle_start), 32'd0);
        chk("rst:decrypt_start", 32'(bus.decrypt_start), 32'd0);
        chk("rst:sel", 32'(bus.s_mem_sel), 32'd3);
        chk("rst:key", 32'(bus.secret_key), 32'd0);
        chk("rst:addr", 32'(bus.result_addr), 32'd0);
        chk("rst:status", 32'({bus.busy, bus.found, bus.not_found}), 32'd0);
        @(negedge clk);
        #2 reset = 1'b0;
        @(negedge clk);

        // key 2 holds "hello world" padded with spaces; key 0 dies on byte 0
        fill_key(0, 0, 8'h41);
        fill_key(1, int'($urandom_range(0, 31)), bchar());
        for (int a = 0; a < ML; a++) ram[2][a] = (a < hello.len()) ? hello[a] : 8'h20;
        first_bad[2] = ML;
        for (int k = 3; k <= KE; k++) fill_key(k, int'($urandom_range(0, 31)), bchar());
        launch();
        wait_and_check("hello");

        // rejects at specific positions with each boundary-adjacent byte
        fill_key(0, 0, 8'h41);
        fill_key(1, 5, 8'h7B);
        fill_key(2, 17, 8'h60);
        fill_key(3, 31, 8'h1F);
        fill_key(4, ML, 8'h00);
        launch();
        wait_and_check("bounds");

        // start held high while in FOUND: restart, found drops on INIT entry
        for (int k = KS; k <= KE; k++) fill_key(k, int'($urandom_range(0, 31)), bchar());
        compute_exp();
        clear_obs();
        bus.start = 1'b1;
        @(negedge clk);
        chk("restart:init_start", 32'(bus.init_start), 32'd1);
        chk("restart:found", 32'(bus.found), 32'd0);
        chk("restart:busy", 32'(bus.busy), 32'd1);
        chk("restart:key", 32'(bus.secret_key), 32'(KS));
        repeat (3) @(negedge clk);
        bus.start = 1'b0;
        wait_and_check("none");

        // randomized searches
        for (int r = 0; r < 5; r++) begin
            for (int k = KS; k <= KE; k++) begin
                if ($urandom_range(0, 3) == 0) fill_key(k, ML, 8'h00);
                else fill_key(k, int'($urandom_range(0, 31)), bchar());
            end
            launch();
            wait_and_check("rand");
        end

        // reset during decrypt of key 5
        for (int k = 0; k < 5; k++) fill_key(k, int'($urandom_range(0, 31)), bchar());
        fill_key(5, ML, 8'h00);
        fill_key(6, ML, 8'h00);
        fill_key(7, int'($urandom_range(0, 31)), bchar());
        launch();
        n = 0;
        while (!(bus.s_mem_sel == 2'd2 && bus.secret_key == 24'd5) && n < 4000) begin
            @(negedge clk);
            n++;
        end
        chk("midrst:reach", 32'(n < 4000), 32'd1);
        #1 reset = 1'b1;
        #1;
        chk("midrst:starts", 32'({bus.init_start, bus.shuffle_start, bus.decrypt_start}), 32'd0);
        chk("midrst:sel", 32'(bus.s_mem_sel), 32'd3);
        chk("midrst:key", 32'(bus.secret_key), 32'd0);
        chk("midrst:addr", 32'(bus.result_addr), 32'd0);
        chk("midrst:status", 32'({bus.busy, bus.found, bus.not_found}), 32'd0);
        @(negedge clk);
        @(negedge clk);
        #2 reset = 1'b0;
        repeat (8) begin
            @(negedge clk);
            chk("midrst:quiet", 32'({bus.init_start, bus.busy}), 32'd0);
        end
        launch();
        wait_and_check("after_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
